// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports, two write ports (B wins on collision),
// register 0 hard-wired to zero, and a self-clearing sequence after reset that gates writes via Ready.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RS1,
    input  logic [ADDR_W-1:0] RS2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              WEA,
    input  logic              WEB,
    input  logic [ADDR_W-1:0] WAA,
    input  logic [ADDR_W-1:0] WAB,
    input  logic [DATA_W-1:0] WDA,
    input  logic [DATA_W-1:0] WDB,
    output logic              Ready
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                ready_q;
    logic [DATA_W-1:0]   mem_q [NREG];
    logic                wr_ok;

    assign wr_ok = (state_q == RUN) && !Reset;
    assign Ready = ready_q;

    // Controller: Reset parks the sequencer at index 1; it walks to the last index, then runs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CLEAR;
            cnt_q   <= ADDR_W'(1);
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                RUN: begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= ADDR_W'(1);
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset of its own; the clear sequence zeroes it. Port B is written last so it wins.
    always_ff @(posedge Clk) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_ok) begin
            if (WEA && (WAA != '0)) mem_q[WAA] <= WDA;
            if (WEB && (WAB != '0)) mem_q[WAB] <= WDB;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if ((state_q == RUN) && (addr != '0)) begin
            val = mem_q[addr];
            if ((BYPASS != 0) && wr_ok) begin
                if (WEB && (WAB == addr))      val = WDB;
                else if (WEA && (WAA == addr)) val = WDA;
            end
        end
        return val;
    endfunction

    always_comb begin
        RD1 = read_port(RS1);
        RD2 = read_port(RS2);
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized bench for reg_file_mp: a default instance (32x32, bypass) and a small instance
// (8x8, no bypass) run side by side against an array-based reference model.
module tb_reg_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic [4:0]  rs1 [2];
    logic [4:0]  rs2 [2];
    logic [4:0]  waa [2];
    logic [4:0]  wab [2];
    logic        wea [2];
    logic        web [2];
    logic [31:0] wda [2];
    logic [31:0] wdb [2];

    logic [31:0] rd1_a, rd2_a;
    logic [7:0]  rd1_b, rd2_b;
    logic        rdy_a, rdy_b;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_a (
        .Clk(clk), .Reset(rst[0]),
        .RS1(rs1[0]), .RS2(rs2[0]), .RD1(rd1_a), .RD2(rd2_a),
        .WEA(wea[0]), .WEB(web[0]), .WAA(waa[0]), .WAB(wab[0]),
        .WDA(wda[0]), .WDB(wdb[0]), .Ready(rdy_a)
    );

    reg_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(0)) u_dut_b (
        .Clk(clk), .Reset(rst[1]),
        .RS1(rs1[1][2:0]), .RS2(rs2[1][2:0]), .RD1(rd1_b), .RD2(rd2_b),
        .WEA(wea[1]), .WEB(web[1]), .WAA(waa[1][2:0]), .WAB(wab[1][2:0]),
        .WDA(wda[1][7:0]), .WDB(wdb[1][7:0]), .Ready(rdy_b)
    );

    // Reference model: plain array contents plus "next register to clear" (0 = clear finished).
    int          nreg  [2] = '{32, 8};
    bit          byp   [2] = '{1'b1, 1'b0};
    logic [31:0] dmask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    string       tg    [2] = '{"a", "b"};
    logic [31:0] mem_m [2][32];
    int          clr   [2];
    bit          valid [2];
    int          rl    [2];

    logic [31:0] samp_rd1 [2];
    logic [31:0] samp_rd2 [2];
    logic        samp_rdy [2];

    int nvec = 0;
    int nerr = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int i, input logic [4:0] a);
        if (clr[i] != 0 || a == 5'd0) return 32'd0;
        if (byp[i] && !rst[i]) begin
            if (web[i] && wab[i] == a) return wdb[i];
            if (wea[i] && waa[i] == a) return wda[i];
        end
        return mem_m[i][a];
    endfunction

    task automatic model_edge(input int i);
        if (rst[i]) begin
            if (valid[i] && clr[i] != 0) mem_m[i][clr[i]] = 32'd0;
            clr[i]   = 1;
            valid[i] = 1'b1;
        end else if (valid[i]) begin
            if (clr[i] != 0) begin
                mem_m[i][clr[i]] = 32'd0;
                clr[i] = (clr[i] == nreg[i] - 1) ? 0 : clr[i] + 1;
            end else begin
                if (wea[i] && waa[i] != 5'd0) mem_m[i][waa[i]] = wda[i];
                if (web[i] && wab[i] != 5'd0) mem_m[i][wab[i]] = wdb[i];
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        samp_rd1[0] = rd1_a;
        samp_rd2[0] = rd2_a;
        samp_rdy[0] = rdy_a;
        samp_rd1[1] = {24'd0, rd1_b};
        samp_rd2[1] = {24'd0, rd2_b};
        samp_rdy[1] = rdy_b;
        for (int i = 0; i < 2; i++) begin
            if (valid[i]) begin
                check_eq({tg[i], "_rd1"}, samp_rd1[i], exp_rd(i, rs1[i]));
                check_eq({tg[i], "_rd2"}, samp_rd2[i], exp_rd(i, rs2[i]));
                check_eq({tg[i], "_ready"}, {31'd0, samp_rdy[i]}, {31'd0, (clr[i] == 0)});
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
    endtask

    task automatic idle(input int i);
        rs1[i] = 5'd0; rs2[i] = 5'd0;
        wea[i] = 1'b0; web[i] = 1'b0;
        waa[i] = 5'd0; wab[i] = 5'd0;
        wda[i] = 32'd0; wdb[i] = 32'd0;
    endtask

    task automatic idle_all();
        idle(0);
        idle(1);
    endtask

    task automatic rnd(input int i);
        int top;
        top = nreg[i] - 1;
        waa[i] = 5'($urandom_range(top, 0));
        wab[i] = ($urandom_range(2, 0) == 0) ? waa[i] : 5'($urandom_range(top, 0));
        rs1[i] = ($urandom_range(2, 0) == 0) ? wab[i] : 5'($urandom_range(top, 0));
        rs2[i] = ($urandom_range(2, 0) == 0) ? waa[i] : 5'($urandom_range(top, 0));
        wea[i] = ($urandom_range(2, 0) != 0);
        web[i] = ($urandom_range(2, 0) != 0);
        wda[i] = $urandom & dmask[i];
        wdb[i] = $urandom & dmask[i];
    endtask

    initial begin
        int a_first, b_first, k;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0;
            clr[i]   = 0;
            rl[i]    = 0;
            for (int r = 0; r < 32; r++) mem_m[i][r] = 32'd0;
        end
        idle_all();
        rst[0] = 1'b1; rst[1] = 1'b1;
        step();
        step();

        // Partial clear, then a reset pulse at clear cycle 10 restarts the sequence.
        rst[0] = 1'b0; rst[1] = 1'b0;
        repeat (10) begin
            rnd(0); rnd(1);
            step();
        end
        rst[0] = 1'b1; rst[1] = 1'b1;
        idle_all();
        step();
        rst[0] = 1'b0; rst[1] = 1'b0;

        a_first = -1;
        b_first = -1;
        k = 0;
        while ((a_first < 0 || b_first < 0) && k < 60) begin
            rnd(0); rnd(1);
            if (k == 0) begin
                wea[0] = 1'b1; waa[0] = 5'd4; wda[0] = 32'hFF; web[0] = 1'b0;
            end
            if (k >= 31) begin
                wea[0] = 1'b0; web[0] = 1'b0;
            end
            step();
            if (samp_rdy[0] && a_first < 0) a_first = k;
            if (samp_rdy[1] && b_first < 0) b_first = k;
            k++;
        end
        check_eq("a_clear_len", a_first, 32'd31);
        check_eq("b_clear_len", b_first, 32'd7);

        for (int r = 1; r < 32; r++) begin
            idle_all();
            rs1[0] = 5'(r); rs2[0] = 5'(r);
            step();
            check_eq("a_cleared", samp_rd1[0], 32'd0);
        end

        // Default instance: basic write/read, writes to r0, dual-port collision.
        idle_all();
        wea[0] = 1'b1; waa[0] = 5'd5; wda[0] = 32'hDEADBEEF;
        step();
        idle_all();
        rs1[0] = 5'd5;
        step();
        check_eq("a_wr5", samp_rd1[0], 32'hDEADBEEF);

        idle_all();
        wea[0] = 1'b1; waa[0] = 5'd0; wda[0] = 32'h1234; rs2[0] = 5'd0;
        step();
        check_eq("a_r0_nofwd", samp_rd2[0], 32'd0);
        idle_all();
        rs2[0] = 5'd0;
        step();
        check_eq("a_r0", samp_rd2[0], 32'd0);

        idle_all();
        wea[0] = 1'b1; web[0] = 1'b1; waa[0] = 5'd7; wab[0] = 5'd7;
        wda[0] = 32'h11; wdb[0] = 32'h22; rs1[0] = 5'd7;
        step();
        check_eq("a_dual_fwd", samp_rd1[0], 32'h22);
        idle_all();
        rs1[0] = 5'd7;
        step();
        check_eq("a_dual_store", samp_rd1[0], 32'h22);

        // Small instance without forwarding.
        idle_all();
        wea[1] = 1'b1; waa[1] = 5'd3; wda[1] = 32'hA;
        step();
        idle_all();
        wea[1] = 1'b1; waa[1] = 5'd3; wda[1] = 32'hB; rs1[1] = 5'd3;
        step();
        check_eq("b_nobypass", samp_rd1[1], 32'hA);
        idle_all();
        rs1[1] = 5'd3;
        step();
        check_eq("b_wr3", samp_rd1[1], 32'hB);

        idle_all();
        wea[1] = 1'b1; waa[1] = 5'd7; wda[1] = 32'hA5;
        step();
        idle_all();
        rs1[1] = 5'd7; rs2[1] = 5'd7;
        step();
        check_eq("b_wr7_rd1", samp_rd1[1], 32'hA5);
        check_eq("b_wr7_rd2", samp_rd2[1], 32'hA5);

        // Random traffic with occasional resets of 1..3 cycles.
        repeat (800) begin
            for (int i = 0; i < 2; i++) begin
                rnd(i);
                if (rl[i] == 0 && $urandom_range(149, 0) == 0) rl[i] = $urandom_range(3, 1);
                rst[i] = (rl[i] != 0);
                if (rl[i] != 0) rl[i]--;
            end
            step();
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        idle_all();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
